// File: rtl/volley_ball_engine_if.sv
// Game-side bundle for the volleyball engine: player inputs in,
// ball/score/state outputs back to the renderer.
interface volley_ball_engine_if #(
    parameter int COORD_W = 10,
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic               p1_cover;
    logic               p2_cover;
    logic [COORD_W-1:0] p1_pos_x;
    logic [COORD_W-1:0] p1_pos_y;
    logic [COORD_W-1:0] p2_pos_x;
    logic [COORD_W-1:0] p2_pos_y;
    logic [COORD_W-1:0] ball_pos_x;
    logic [COORD_W-1:0] ball_pos_y;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [2:0]         state;
    logic               point_p1;
    logic               point_p2;
    logic               game_over;

    modport master (
        output frame_tick, start, p1_cover, p2_cover,
        output p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y,
        input  ball_pos_x, ball_pos_y, p1_score, p2_score,
        input  state, point_p1, point_p2, game_over
    );

    modport slave (
        input  frame_tick, start, p1_cover, p2_cover,
        input  p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y,
        output ball_pos_x, ball_pos_y, p1_score, p2_score,
        output state, point_p1, point_p2, game_over
    );
endinterface

// File: rtl/volley_ball_engine.sv
// Volleyball ball physics plus match FSM (serve/play/point/over).
// Define VOLLEY_DAMPING_EN to damp every reflection to 7/8.
module volley_ball_engine #(
    parameter int COORD_W      = 10,
    parameter int FRAC_W       = 6,
    parameter int SCORE_W      = 4,
    parameter int SCREEN_W     = 320,
    parameter int FLOOR_Y      = 30,
    parameter int NET_X        = 160,
    parameter int NET_HALF_W   = 6,
    parameter int NET_H        = 90,
    parameter int SERVE_Y      = 150,
    parameter int GRAVITY      = 2,
    parameter int HIT_VX       = 192,
    parameter int HIT_VY       = 320,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 60
) (
    input logic                 clk,
    input logic                 rst_n,
    volley_ball_engine_if.slave bus
);
    localparam int PW      = COORD_W + FRAC_W;
    localparam int SW      = PW + 2;
    localparam int ONE     = 1 << FRAC_W;
    localparam int NET_TOP = FLOOR_Y + NET_H;
    localparam int CNT_W   = $clog2(PAUSE_FRAMES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic signed [SW-1:0] FLOOR_FX = SW'(FLOOR_Y * ONE);
    localparam logic signed [SW-1:0] NET_FX   = SW'(NET_X * ONE);
    localparam logic signed [SW-1:0] NET_LO   = SW'((NET_X - NET_HALF_W) * ONE);
    localparam logic signed [SW-1:0] NET_HI   = SW'((NET_X + NET_HALF_W) * ONE);
    localparam logic signed [SW-1:0] TOP_FX   = SW'(NET_TOP * ONE);
    localparam logic signed [SW-1:0] WALL_FX  = SW'((SCREEN_W - 1) * ONE);

    localparam logic [PW-1:0] SRV1_X = PW'((SCREEN_W / 4) * ONE);
    localparam logic [PW-1:0] SRV2_X = PW'((3 * SCREEN_W / 4) * ONE);
    localparam logic [PW-1:0] SRV_Y  = PW'(SERVE_Y * ONE);

    localparam logic [COORD_W-1:0]        HIT_OFS = COORD_W'(30);
    localparam logic signed [COORD_W-1:0] VX_HIT  = COORD_W'(HIT_VX);
    localparam logic signed [COORD_W-1:0] VY_HIT  = COORD_W'(HIT_VY);
    localparam logic signed [COORD_W-1:0] GRAV    = COORD_W'(GRAVITY);
    localparam logic [SCORE_W-1:0]        WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]          P_LAST  = CNT_W'(PAUSE_FRAMES - 1);

    logic [2:0]                st, st_n;
    logic [PW-1:0]             px, py, px_n, py_n;
    logic signed [COORD_W-1:0] vx, vy, vx_n, vy_n, vy_g;
    logic [SCORE_W-1:0]        s1, s2, s1_n, s2_n;
    logic                      srv, srv_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic                      pt1, pt2, pt1_n, pt2_n;
    logic                      go, go_n;
    logic signed [SW-1:0]      pxs, pys, cx, cy;
    logic [COORD_W-1:0]        h1x, h1y, h2x, h2y;
    logic                      hit1, hit2;

    function automatic logic signed [COORD_W-1:0] refl(
        input logic signed [COORD_W-1:0] v
    );
        logic signed [COORD_W-1:0] n;
        n = -v;
`ifdef VOLLEY_DAMPING_EN
        refl = n - (n >>> 3);
`else
        refl = n;
`endif
    endfunction

    function automatic logic [SCORE_W-1:0] bump(
        input logic [SCORE_W-1:0] s
    );
        bump = (s < WIN) ? s + 1'b1 : s;
    endfunction

    always_comb begin
        vy_g = vy - GRAV;
        pxs  = $signed({2'b00, px});
        pys  = $signed({2'b00, py});
        cx   = pxs + $signed({{(SW-COORD_W){vx[COORD_W-1]}}, vx});
        cy   = pys + $signed({{(SW-COORD_W){vy_g[COORD_W-1]}}, vy_g});
        h1x  = bus.p1_pos_x + HIT_OFS;
        h1y  = bus.p1_pos_y + HIT_OFS;
        h2x  = bus.p2_pos_x - HIT_OFS;
        h2y  = bus.p2_pos_y + HIT_OFS;
    end

    always_comb begin
        st_n  = st;
        px_n  = px;
        py_n  = py;
        vx_n  = vx;
        vy_n  = vy;
        s1_n  = s1;
        s2_n  = s2;
        srv_n = srv;
        cnt_n = cnt;
        go_n  = go;
        pt1_n = 1'b0;
        pt2_n = 1'b0;
        hit1  = 1'b0;
        hit2  = 1'b0;
        case (st)
            S_IDLE: begin
                if (bus.start) begin
                    st_n  = S_SERVE;
                    srv_n = 1'b0;
                    px_n  = SRV1_X;
                    py_n  = SRV_Y;
                    vx_n  = '0;
                    vy_n  = '0;
                    s1_n  = '0;
                    s2_n  = '0;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    hit1 = !srv && bus.p1_cover;
                    hit2 = srv && bus.p2_cover;
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    // Simultaneous covers go to the player on the ball's side.
                    if (bus.p1_cover && (!bus.p2_cover || pxs < NET_FX)) begin
                        hit1 = 1'b1;
                    end else if (bus.p2_cover) begin
                        hit2 = 1'b1;
                    end else if (cy <= FLOOR_FX) begin
                        st_n  = S_POINT;
                        cnt_n = '0;
                        if (cx < NET_FX) begin
                            s2_n  = bump(s2);
                            pt2_n = 1'b1;
                            srv_n = 1'b1;
                        end else begin
                            s1_n  = bump(s1);
                            pt1_n = 1'b1;
                            srv_n = 1'b0;
                        end
                    end else if (pxs > NET_LO && pxs < NET_HI &&
                                 pys > TOP_FX && cy <= TOP_FX) begin
                        py_n = TOP_FX[PW-1:0];
                        vy_n = refl(vy);
                    end else if (cx > NET_LO && cx < NET_HI &&
                                 cy > FLOOR_FX && cy <= TOP_FX) begin
                        vx_n = refl(vx);
                        px_n = (pxs < NET_FX) ? NET_LO[PW-1:0]
                                              : NET_HI[PW-1:0];
                    end else if (cx[SW-1] || cx == '0) begin
                        px_n = '0;
                        vx_n = refl(vx);
                    end else if (cx >= WALL_FX) begin
                        px_n = WALL_FX[PW-1:0];
                        vx_n = refl(vx);
                    end else begin
                        px_n = cx[PW-1:0];
                        py_n = cy[PW-1:0];
                        vy_n = vy_g;
                    end
                end
            end
            S_POINT: begin
                if (bus.frame_tick) begin
                    if (cnt == P_LAST) begin
                        cnt_n = '0;
                        if (s1 == WIN || s2 == WIN) begin
                            st_n = S_OVER;
                            go_n = 1'b1;
                        end else begin
                            st_n = S_SERVE;
                            px_n = srv ? SRV2_X : SRV1_X;
                            py_n = SRV_Y;
                            vx_n = '0;
                            vy_n = '0;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    st_n  = S_SERVE;
                    srv_n = 1'b0;
                    px_n  = SRV1_X;
                    py_n  = SRV_Y;
                    vx_n  = '0;
                    vy_n  = '0;
                    s1_n  = '0;
                    s2_n  = '0;
                    go_n  = 1'b0;
                end
            end
            default: st_n = S_IDLE;
        endcase
        if (hit1) begin
            st_n = S_PLAY;
            px_n = {h1x, {FRAC_W{1'b0}}};
            py_n = {h1y, {FRAC_W{1'b0}}};
            vx_n = VX_HIT;
            vy_n = VY_HIT;
        end else if (hit2) begin
            st_n = S_PLAY;
            px_n = {h2x, {FRAC_W{1'b0}}};
            py_n = {h2y, {FRAC_W{1'b0}}};
            vx_n = -VX_HIT;
            vy_n = VY_HIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= S_IDLE;
            px  <= SRV1_X;
            py  <= SRV_Y;
            vx  <= '0;
            vy  <= '0;
            s1  <= '0;
            s2  <= '0;
            srv <= 1'b0;
            cnt <= '0;
            pt1 <= 1'b0;
            pt2 <= 1'b0;
            go  <= 1'b0;
        end else begin
            st  <= st_n;
            px  <= px_n;
            py  <= py_n;
            vx  <= vx_n;
            vy  <= vy_n;
            s1  <= s1_n;
            s2  <= s2_n;
            srv <= srv_n;
            cnt <= cnt_n;
            pt1 <= pt1_n;
            pt2 <= pt2_n;
            go  <= go_n;
        end
    end

    assign bus.ball_pos_x = px[PW-1:FRAC_W];
    assign bus.ball_pos_y = py[PW-1:FRAC_W];
    assign bus.p1_score   = s1;
    assign bus.p2_score   = s2;
    assign bus.state      = st;
    assign bus.point_p1   = pt1;
    assign bus.point_p2   = pt2;
    assign bus.game_over  = go;
endmodule
